// File: rtl/adc_frame_aligner.sv
// adc_frame_aligner: deserializes the ADC bit stream, applies bitslips and checks the training word
module adc_frame_aligner #(
  parameter int               WIDTH     = 12,
  parameter logic [WIDTH-1:0] PATTERN   = 12'hFC0,
  parameter int               MATCH_CNT = 4
) (
  input  logic                     clk,
  input  logic                     rstb,
  input  logic                     din,
  input  logic                     din_en,
  input  logic                     bitsleep,
  input  logic                     clr,
  output logic [WIDTH-1:0]         word,
  output logic                     word_valid,
  output logic                     dch_ok,
  output logic [$clog2(WIDTH)-1:0] slip_cnt
);
  localparam int CW = $clog2(WIDTH);
  typedef enum logic [1:0] {HUNT, CHECK, LOCKED} state_t;
  state_t           state, state_nx;
  logic [3:0]       cnt, cnt_nx, inc;
  logic [WIDTH-1:0] sr, sr_nx;
  logic [CW-1:0]    bcnt;
  logic             pending, slip_acc, take, hit;
  assign slip_acc = bitsleep && !pending;
  assign take     = din_en && !pending;
  assign sr_nx    = {sr[WIDTH-2:0], din};
  assign dch_ok   = state == LOCKED;
  // Deserializer: a pending slip swallows the next qualified bit instead of shifting it
  always_ff @(posedge clk or negedge rstb) begin
    if (!rstb) begin
      sr         <= '0;
      bcnt       <= '0;
      word       <= '0;
      word_valid <= 1'b0;
      pending    <= 1'b0;
    end else begin
      word_valid <= 1'b0;
      if (slip_acc) pending <= 1'b1;
      else if (din_en && pending) pending <= 1'b0;
      if (take) begin
        sr <= sr_nx;
        bcnt <= (bcnt == CW'(WIDTH - 1)) ? '0 : bcnt + 1'b1;
        if (bcnt == CW'(WIDTH - 1)) begin
          word       <= sr_nx;
          word_valid <= 1'b1;
        end
      end
    end
  end
  // Slip counter: counts accepted slips modulo WIDTH, cleared by clr
  always_ff @(posedge clk or negedge rstb) begin
    if (!rstb) slip_cnt <= '0;
    else slip_cnt <= clr ? '0 : slip_acc ? ((slip_cnt == CW'(WIDTH - 1)) ? '0 : slip_cnt + 1'b1) : slip_cnt;
  end
  // Checker state register
  always_ff @(posedge clk or negedge rstb) begin
    if (!rstb) begin
      state <= HUNT;
      cnt   <= '0;
    end else begin
      state <= state_nx;
      cnt   <= cnt_nx;
    end
  end
  // Checker next state: clr and accepted slips override any word compare this cycle
  always_comb begin
    inc      = cnt + 4'd1;
    hit      = word == PATTERN;
    state_nx = state;
    cnt_nx   = cnt;
    if (clr || slip_acc) begin
      state_nx = HUNT;
      cnt_nx   = '0;
    end else if (word_valid) begin
      state_nx = !hit ? HUNT : (state == LOCKED || inc == 4'(MATCH_CNT)) ? LOCKED : CHECK;
      cnt_nx   = !hit ? '0 : (state == LOCKED) ? cnt : inc;
    end
  end
endmodule

// File: tb/tb_adc_frame_aligner.sv
// tb_adc_frame_aligner: scoreboard bench for the ADC frame aligner
module tb_adc_frame_aligner;
  localparam int W = 12;
  logic         clk = 1'b0, rstb = 1'b0, din = 1'b0, din_en = 1'b0, bitsleep = 1'b0, clr = 1'b0;
  logic [W-1:0] word;
  logic         word_valid, dch_ok;
  logic [3:0]   slip_cnt;
  int           tests = 0, fails = 0;
  logic [W-1:0] q[$];
  logic [W-1:0] m_sr = '0, exp_w, cur_pat = 12'h1F8;
  int           m_cnt = 0, sp = 0;
  bit           m_pend = 0;

  always #5 clk = ~clk;

  adc_frame_aligner #(.WIDTH(W), .PATTERN(12'hFC0), .MATCH_CNT(4)) dut (
    .clk(clk), .rstb(rstb), .din(din), .din_en(din_en), .bitsleep(bitsleep), .clr(clr),
    .word(word), .word_valid(word_valid), .dch_ok(dch_ok), .slip_cnt(slip_cnt)
  );

  // scoreboard: every assembled word must match the next word predicted by the bit model
  always @(negedge clk) begin
    if (rstb && word_valid) begin
      tests++;
      if (q.size() == 0) begin
        fails++;
        $display("FAIL word_unexpected: got %h, none expected", word);
      end else begin
        exp_w = q.pop_front();
        if (word !== exp_w) begin
          fails++;
          $display("FAIL word: got %h, expected %h", word, exp_w);
        end
      end
    end
  end

  task automatic tick(input logic d, input logic en, input logic bs, input logic c);
    bit p0;
    din = d; din_en = en; bitsleep = bs; clr = c;
    @(posedge clk);
    if (rstb) begin
      p0 = m_pend;
      if (bs && !p0) m_pend = 1;
      else if (en && p0) m_pend = 0;
      if (en && !p0) begin
        m_sr = {m_sr[W-2:0], d};
        if (m_cnt == W - 1) begin
          q.push_back(m_sr);
          m_cnt = 0;
        end else m_cnt++;
      end
    end
    #1;
    din_en = 0; bitsleep = 0; clr = 0;
  endtask

  task automatic idle();
    tick(1'b0, 1'b0, 1'b0, 1'b0);
  endtask

  task automatic send_word(input logic [W-1:0] w);
    for (int i = W - 1; i >= 0; i--) tick(w[i], 1'b1, 1'b0, 1'b0);
  endtask

  task automatic sb(input logic bs);
    tick(cur_pat[W-1-sp], 1'b1, bs, 1'b0);
    sp = (sp + 1) % W;
  endtask

  task automatic stream(input int n);
    for (int i = 0; i < n; i++) sb(1'b0);
  endtask

  task automatic do_reset();
    #2 rstb = 0;
    #1 tests++;
    if ({word, word_valid, dch_ok, slip_cnt} !== '0) begin
      fails++;
      $display("FAIL async_reset: got word=%h v=%b ok=%b slip=%0d, expected all 0", word, word_valid, dch_ok, slip_cnt);
    end
    @(posedge clk); #1 rstb = 1;
    m_sr = '0; m_cnt = 0; m_pend = 0; sp = 0;
    q.delete();
  endtask

  task automatic test_reset();
    logic [W-1:0] fc0 = 12'hFC0;
    for (int i = 0; i < 6; i++) begin
      tick(1'($urandom), 1'($urandom), 1'b0, 1'b0);
      tests++;
      if ({word, word_valid, dch_ok, slip_cnt} !== '0) begin
        fails++;
        $display("FAIL reset_hold: got word=%h v=%b ok=%b slip=%0d, expected all 0", word, word_valid, dch_ok, slip_cnt);
      end
    end
    @(negedge clk) rstb = 1;
    m_sr = '0; m_cnt = 0; m_pend = 0;
    for (int i = W - 1; i >= 1; i--) tick(fc0[i], 1'b1, 1'b0, 1'b0);
    tests++;
    if (word_valid !== 1'b0) begin fails++; $display("FAIL early_valid: got %b, expected 0", word_valid); end
    tick(fc0[0], 1'b1, 1'b0, 1'b0);
    tests++;
    if ({word_valid, word, dch_ok} !== {1'b1, 12'hFC0, 1'b0}) begin
      fails++;
      $display("FAIL first_word: got v=%b word=%h ok=%b, expected v=1 word=fc0 ok=0", word_valid, word, dch_ok);
    end
    idle();
    tests++;
    if (word_valid !== 1'b0) begin fails++; $display("FAIL valid_pulse: got %b, expected 0", word_valid); end
  endtask

  task automatic test_lock();
    tick(1'b0, 1'b0, 1'b0, 1'b1);
    for (int i = 0; i < 4; i++) send_word(12'hFC0);
    tests++;
    if (dch_ok !== 1'b0) begin fails++; $display("FAIL lock_early: got %b, expected 0", dch_ok); end
    idle();
    tests++;
    if (dch_ok !== 1'b1) begin fails++; $display("FAIL lock_rise: got %b, expected 1", dch_ok); end
    send_word(12'hFC0); send_word(12'hFC0); idle();
    tests++;
    if (dch_ok !== 1'b1) begin fails++; $display("FAIL lock_hold: got %b, expected 1", dch_ok); end
  endtask

  task automatic test_slip_align();
    tick(1'b0, 1'b0, 1'b0, 1'b1);
    tests++;
    if ({dch_ok, slip_cnt} !== 5'd0) begin fails++; $display("FAIL clr: got ok=%b slip=%0d, expected 0/0", dch_ok, slip_cnt); end
    cur_pat = 12'h1F8; sp = 0;
    stream(24);
    tests++;
    if (word !== 12'h1F8) begin fails++; $display("FAIL unslipped: got %h, expected 1f8", word); end
    for (int k = 1; k <= 3; k++) begin
      sb(1'b1); stream(5);
      tests++;
      if (slip_cnt !== 4'(k)) begin fails++; $display("FAIL slip_count: got %0d, expected %0d", slip_cnt, k); end
    end
    stream(72); idle();
    tests++;
    if ({dch_ok, word} !== {1'b1, 12'hFC0}) begin
      fails++;
      $display("FAIL aligned: got ok=%b word=%h, expected ok=1 word=fc0", dch_ok, word);
    end
  endtask

  task automatic test_slip_rules();
    sb(1'b1);
    tests++;
    if ({dch_ok, slip_cnt} !== {1'b0, 4'd4}) begin
      fails++;
      $display("FAIL slip_unlock: got ok=%b slip=%0d, expected ok=0 slip=4", dch_ok, slip_cnt);
    end
    stream(3);
    sb(1'b1); sb(1'b1); stream(2);
    tests++;
    if (slip_cnt !== 4'd5) begin fails++; $display("FAIL double_slip: got %0d, expected 5", slip_cnt); end
    tick(1'b0, 1'b0, 1'b0, 1'b1);
    for (int k = 1; k <= 12; k++) begin
      sb(1'b1); sb(1'b0);
      if (k == 11) begin
        tests++;
        if (slip_cnt !== 4'd11) begin fails++; $display("FAIL slip_max: got %0d, expected 11", slip_cnt); end
      end
    end
    tests++;
    if (slip_cnt !== 4'd0) begin fails++; $display("FAIL slip_wrap: got %0d, expected 0", slip_cnt); end
  endtask

  task automatic test_loss_of_lock();
    do_reset();
    for (int i = 0; i < 4; i++) send_word(12'hFC0);
    idle();
    tests++;
    if (dch_ok !== 1'b1) begin fails++; $display("FAIL relock: got %b, expected 1", dch_ok); end
    send_word(12'hFC1);
    tests++;
    if (dch_ok !== 1'b1) begin fails++; $display("FAIL bad_word_hold: got %b, expected 1", dch_ok); end
    idle();
    tests++;
    if (dch_ok !== 1'b0) begin fails++; $display("FAIL bad_word_drop: got %b, expected 0", dch_ok); end
    for (int i = 0; i < 3; i++) send_word(12'hFC0);
    idle();
    tests++;
    if (dch_ok !== 1'b0) begin fails++; $display("FAIL relock_early: got %b, expected 0", dch_ok); end
    send_word(12'hFC0); idle();
    tests++;
    if (dch_ok !== 1'b1) begin fails++; $display("FAIL relock_after_loss: got %b, expected 1", dch_ok); end
  endtask

  task automatic test_collisions();
    tick(1'b0, 1'b0, 1'b0, 1'b1);
    for (int i = 0; i < 4; i++) send_word(12'hFC0);
    tick(1'b0, 1'b0, 1'b0, 1'b1);
    tests++;
    if (dch_ok !== 1'b0) begin fails++; $display("FAIL clr_collision: got %b, expected 0", dch_ok); end
    for (int i = 0; i < 3; i++) send_word(12'hFC0);
    tick(1'b0, 1'b0, 1'b1, 1'b0);
    tests++;
    if ({dch_ok, slip_cnt} !== {1'b0, 4'd1}) begin
      fails++;
      $display("FAIL slip_collision: got ok=%b slip=%0d, expected ok=0 slip=1", dch_ok, slip_cnt);
    end
    tick(1'b1, 1'b1, 1'b0, 1'b0);
    for (int i = 0; i < 3; i++) send_word(12'hFC0);
    idle();
    tests++;
    if (dch_ok !== 1'b0) begin fails++; $display("FAIL slip_count_restart: got %b, expected 0", dch_ok); end
    send_word(12'hFC0); idle();
    tests++;
    if (dch_ok !== 1'b1) begin fails++; $display("FAIL lock_after_slip: got %b, expected 1", dch_ok); end
    for (int i = 0; i < 5; i++) tick(1'b1, 1'b1, 1'b0, 1'b0);
    tick(1'b0, 1'b0, 1'b1, 1'b0);
    do_reset();
    send_word(12'hFC0);
    tests++;
    if ({word_valid, word} !== {1'b1, 12'hFC0}) begin
      fails++;
      $display("FAIL reset_midword: got v=%b word=%h, expected v=1 word=fc0", word_valid, word);
    end
    for (int i = 0; i < 3; i++) send_word(12'hFC0);
    idle();
    tests++;
    if ({dch_ok, slip_cnt} !== {1'b1, 4'd0}) begin
      fails++;
      $display("FAIL lock_after_reset: got ok=%b slip=%0d, expected ok=1 slip=0", dch_ok, slip_cnt);
    end
  endtask

  initial begin
    test_reset();
    test_lock();
    test_slip_align();
    test_slip_rules();
    test_loss_of_lock();
    test_collisions();
    idle(); idle();
    tests++;
    if (q.size() != 0) begin fails++; $display("FAIL words_missing: got %0d outstanding, expected 0", q.size()); end
    $display("[TB] %0d tests run, %0d failed", tests, fails);
    $finish;
  end
endmodule
